// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide issue controller:
// op codes, MulDiv select codes, FSM states and counter width.
package md_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  localparam logic [1:0] SEL_MULT  = 2'b00;
  localparam logic [1:0] SEL_MULTU = 2'b01;
  localparam logic [1:0] SEL_DIV   = 2'b10;
  localparam logic [1:0] SEL_DIVU  = 2'b11;
  localparam logic [1:0] SEL_HI    = 2'b01;
  localparam logic [1:0] SEL_LO    = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Codes 9-15 are not MD-class and behave as NONE.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Down-counter tracking the remaining busy cycles of a MulDiv operation.
module md_lat_counter
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issues E-stage MD-class ops to the shared MulDiv unit and stalls while it is occupied.
// Optional stall-cycle counter enabled by defining MD_STALL_CNT_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        md_busy,
  input  logic [31:0] md_c,
  output logic        md_start,
  output logic        md_we,
  output logic [1:0]  md_sel,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] stall_cnt
);

  // The counter holds the RUN cycles left after the current one, so RUN
  // (and hence stall) lasts exactly MUL_LAT / DIV_LAT cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e        state_reg, state_next;
  logic             occupied, accept, md_req;
  logic             is_arith, is_mul, is_mt, is_mf;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  assign md_a = req_a;
  assign md_b = req_b;

  assign md_req   = is_md_op(req_op);
  assign occupied = (state_reg == RUN) | md_busy;
  assign stall    = md_req & occupied & ~flush;
  assign accept   = md_req & ~occupied & ~flush;

  assign is_mul   = (req_op == OP_MULT) | (req_op == OP_MULTU);
  assign is_arith = is_mul | (req_op == OP_DIV) | (req_op == OP_DIVU);
  assign is_mt    = (req_op == OP_MTHI) | (req_op == OP_MTLO);
  assign is_mf    = (req_op == OP_MFHI) | (req_op == OP_MFLO);

  always_comb begin
    md_sel = SEL_LO;
    case (req_op)
      OP_MULT:          md_sel = SEL_MULT;
      OP_MULTU:         md_sel = SEL_MULTU;
      OP_DIV:           md_sel = SEL_DIV;
      OP_DIVU:          md_sel = SEL_DIVU;
      OP_MTHI, OP_MFHI: md_sel = SEL_HI;
      default:          md_sel = SEL_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    md_start     = 1'b0;
    md_we        = 1'b0;
    rd_data      = '0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = is_mul ? MUL_LOAD : DIV_LOAD;
    case (state_reg)
      IDLE: begin
        if (accept && is_arith) begin
          md_start   = 1'b1;
          cnt_load   = 1'b1;
          state_next = RUN;
        end
        md_we = accept & is_mt;
        if (accept && is_mf) begin
          rd_data = md_c;
        end
      end
      RUN: begin
        cnt_dec = ~cnt_zero;
        // A slow unit keeps us in RUN past the nominal latency.
        if (cnt_zero && !md_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  md_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed, table-driven bench for md_issue_ctrl with a behavioural MulDiv model.
module tb_md_issue_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef MD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush, md_busy;
  logic [31:0] md_c;
  logic        md_start, md_we, stall;
  logic [1:0]  md_sel;
  logic [31:0] md_a, md_b, rd_data, stall_cnt;

  logic [31:0] hi_q = '0;
  logic [31:0] lo_q = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .flush(flush), .md_busy(md_busy), .md_c(md_c), .md_start(md_start),
    .md_we(md_we), .md_sel(md_sel), .md_a(md_a), .md_b(md_b), .stall(stall),
    .rd_data(rd_data), .stall_cnt(stall_cnt)
  );

  // Behavioural MulDiv: result lands in HI/LO at start; reads select HI on 01.
  assign md_c = (md_sel == 2'b01) ? hi_q : lo_q;

  always @(posedge clk) begin
    if (md_start) begin
      case (md_sel)
        2'b00: {hi_q, lo_q} <= $signed(md_a) * $signed(md_b);
        2'b01: {hi_q, lo_q} <= {32'd0, md_a} * {32'd0, md_b};
        2'b10: if (md_b != 0) begin
                 hi_q <= $signed(md_a) % $signed(md_b);
                 lo_q <= $signed(md_a) / $signed(md_b);
               end else begin
                 hi_q <= md_a;
                 lo_q <= '1;
               end
        default: if (md_b != 0) begin
                 hi_q <= md_a % md_b;
                 lo_q <= md_a / md_b;
               end else begin
                 hi_q <= md_a;
                 lo_q <= '1;
               end
      endcase
    end else if (md_we) begin
      if (md_sel == 2'b01) hi_q <= md_a;
      else                 lo_q <= md_a;
    end
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        fl;
    logic        start;
    logic        we;
    logic        st;
    logic [31:0] rd;
    logic [1:0]  sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic fl, input logic s, input logic w, input logic st,
                     input logic [31:0] rd, input logic [1:0] sel);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.fl = fl; v.start = s; v.we = w;
    v.st = st; v.rd = rd; v.sel = sel;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic busy);
    req_op = op; req_a = a; req_b = b; flush = fl; md_busy = busy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Scenario 1: mult 0x17*0x21, mflo/mfhi after exactly MUL_LAT stall cycles
    add(4'd1, 32'h17, 32'h21, 0, 1, 0, 0, 32'h0, 2'b00);
    for (int k = 0; k < MUL_LAT; k++) add(4'd8, 0, 0, 0, 0, 0, 1, 32'h0, 2'b00);
    add(4'd8, 0, 0, 0, 0, 0, 0, 32'h0000_02F7, 2'b00);
    add(4'd7, 0, 0, 0, 0, 0, 0, 32'h0, 2'b01);
    // Scenario 2: divu 100/7 then mfhi/mflo
    add(4'd4, 32'd100, 32'd7, 0, 1, 0, 0, 32'h0, 2'b11);
    for (int k = 0; k < DIV_LAT; k++) add(4'd7, 0, 0, 0, 0, 0, 1, 32'h0, 2'b01);
    add(4'd7, 0, 0, 0, 0, 0, 0, 32'd2, 2'b01);
    add(4'd8, 0, 0, 0, 0, 0, 0, 32'd14, 2'b00);
    // Scenario 3: back-to-back mult, stall held until the first IDLE cycle
    add(4'd1, 32'd3, 32'd5, 0, 1, 0, 0, 32'h0, 2'b00);
    for (int k = 0; k < MUL_LAT; k++) add(4'd1, 32'd7, 32'd9, 0, 0, 0, 1, 32'h0, 2'b00);
    add(4'd1, 32'd7, 32'd9, 0, 1, 0, 0, 32'h0, 2'b00);
    for (int k = 0; k < MUL_LAT; k++) add(4'd0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00);
    add(4'd8, 0, 0, 0, 0, 0, 0, 32'd63, 2'b00);
    // Scenario 4: mthi with and without flush, mfhi with flush
    add(4'd5, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 32'h0, 2'b01);
    add(4'd5, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 32'h0, 2'b01);
    add(4'd7, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b01);
    add(4'd7, 0, 0, 1, 0, 0, 0, 32'h0, 2'b01);
    add(4'd9, 32'h1, 32'h2, 0, 0, 0, 0, 32'h0, 2'b00);
    // Divide by zero still occupies DIV_LAT cycles; then mtlo/mflo
    add(4'd3, 32'd5, 32'd0, 0, 1, 0, 0, 32'h0, 2'b10);
    for (int k = 0; k < DIV_LAT; k++) add(4'd6, 32'h55, 0, 0, 0, 0, 1, 32'h0, 2'b00);
    add(4'd6, 32'h55, 0, 0, 0, 1, 0, 32'h0, 2'b00);
    add(4'd8, 0, 0, 0, 0, 0, 0, 32'h55, 2'b00);

    #8;
    check("rst_start", {31'd0, md_start}, 32'd0);
    check("rst_we", {31'd0, md_we}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rd", rd_data, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    #3 rst = 1'b0;
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fl, 1'b0);
      #4;
      $display("[TB] vec %0d op=%0d flush=%0b start=%0b we=%0b stall=%0b sel=%0d rd=%h",
               i, vecs[i].op, vecs[i].fl, md_start, md_we, stall, md_sel, rd_data);
      check($sformatf("v%0d_start", i), {31'd0, md_start}, {31'd0, vecs[i].start});
      check($sformatf("v%0d_we", i), {31'd0, md_we}, {31'd0, vecs[i].we});
      check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].st});
      check($sformatf("v%0d_rd", i), rd_data, vecs[i].rd);
      check($sformatf("v%0d_sel", i), {30'd0, md_sel}, {30'd0, vecs[i].sel});
      check($sformatf("v%0d_a", i), md_a, vecs[i].a);
      check($sformatf("v%0d_b", i), md_b, vecs[i].b);
      if (i == 7) check("stall_cnt_s1", stall_cnt, CNT_EN ? 32'd5 : 32'd0);
      next_cycle();
    end

    // Delayed busy: unit stays busy 3 cycles past the nominal latency
    drive(4'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    #4 check("busy_start", {31'd0, md_start}, 32'd1);
    next_cycle();
    for (int k = 1; k <= MUL_LAT + 3; k++) begin
      drive(4'd8, 0, 0, 1'b0, (k <= MUL_LAT + 2));
      #4;
      $display("[TB] busy cycle %0d md_busy=%0b stall=%0b", k, md_busy, stall);
      check($sformatf("busy_stall_%0d", k), {31'd0, stall}, 32'd1);
      next_cycle();
    end
    drive(4'd8, 0, 0, 1'b0, 1'b0);
    #4;
    $display("[TB] busy release stall=%0b rd=%h", stall, rd_data);
    check("busy_release_stall", {31'd0, stall}, 32'd0);
    check("busy_release_rd", rd_data, 32'd6);
    next_cycle();

    // Reset asserted mid-RUN drops stall without waiting for a clock edge
    drive(4'd1, 32'd4, 32'd5, 1'b0, 1'b0);
    #4 check("rr_start", {31'd0, md_start}, 32'd1);
    next_cycle();
    drive(4'd8, 0, 0, 1'b0, 1'b0);
    #4 check("rr_stall_before", {31'd0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    $display("[TB] async reset stall=%0b stall_cnt=%0d", stall, stall_cnt);
    check("rr_stall_async", {31'd0, stall}, 32'd0);
    check("rr_stall_cnt", stall_cnt, 32'd0);
    #5 rst = 1'b0;
    next_cycle();
    #4;
    $display("[TB] after reset mflo stall=%0b rd=%h", stall, rd_data);
    check("rr_after_stall", {31'd0, stall}, 32'd0);
    check("rr_after_rd", rd_data, 32'd20);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
